// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit processor: opcodes, sequencer states, default opcode width.
package cpu_pkg;

  localparam int OP_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_BEQ   = 3'b101,
    OP_NOP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_READ_I = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } seq_state_t;

  // Opcodes that need an operand access in EXEC.
  function automatic logic is_mem_op(opcode_t o);
    return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Sequencer <-> datapath/memory strobe bundle. master = sequencer, slave = datapath side.
interface sequencer_if #(parameter int OP_W = cpu_pkg::OP_W_DEFAULT);
  logic [OP_W-1:0] op;
  logic z_flag, mem_ready;
  logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
  logic ALU_add, ALU_sub, CS, R_NW, halted;

  modport master (
    input  op, z_flag, mem_ready,
    output ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
           ALU_add, ALU_sub, CS, R_NW, halted
  );

  modport slave (
    output op, z_flag, mem_ready,
    input  ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
           ALU_add, ALU_sub, CS, R_NW, halted
  );
endinterface

// File: rtl/sequencer.sv
// Fetch/decode/execute control FSM; strobes are a combinational decode of state and inputs.
module sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  sequencer_if.master  bus
);

  seq_state_t state_q, state_d;
  opcode_t    op_c;

  // Opcodes with any upper bit set (OP_W > 3) fall back to NOP.
  assign op_c = (bus.op == OP_W'(bus.op[2:0])) ? opcode_t'(bus.op[2:0]) : OP_NOP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.PC_bus   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_IR  = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_MAR = 1'b0;
    bus.ALU_add  = 1'b0;
    bus.ALU_sub  = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b0;
    bus.halted   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.PC_bus   = 1'b1;
          bus.load_MAR = 1'b1;
          bus.load_PC  = 1'b1;
          bus.INC_PC   = 1'b1;
          state_d      = S_READ_I;
        end
        S_READ_I: begin
          bus.CS   = 1'b1;
          bus.R_NW = 1'b1;
          if (bus.mem_ready) begin
            bus.load_IR = 1'b1;
            state_d     = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.Addr_bus = 1'b1;
          if (is_mem_op(op_c)) begin
            bus.load_MAR = 1'b1;
            state_d      = S_EXEC;
          end else begin
            case (op_c)
              OP_BNE:  bus.load_PC = ~bus.z_flag;
              OP_BEQ:  bus.load_PC = bus.z_flag;
              default: bus.load_PC = 1'b0;
            endcase
            state_d = (op_c == OP_HALT) ? S_HALT : S_FETCH;
          end
        end
        S_EXEC: begin
          bus.CS = 1'b1;
          if (op_c == OP_STORE) begin
            bus.ACC_bus = 1'b1;
          end else begin
            // LOAD passes the bus straight through the ALU.
            bus.R_NW = 1'b1;
            if (bus.mem_ready) begin
              bus.load_ACC = 1'b1;
              bus.ALU_add  = (op_c == OP_ADD);
              bus.ALU_sub  = (op_c == OP_SUB);
            end
          end
          if (bus.mem_ready) state_d = S_FETCH;
        end
        S_HALT:  bus.halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: strobe sequences per opcode, wait states, reset and halt.
module tb_sequencer;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  sequencer_if #(.OP_W(3)) bus();
  sequencer #(.OP_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Strobe bit positions within the packed observation word.
  localparam logic [12:0] B_ACCB = 13'h1000, B_LACC = 13'h0800, B_PCB  = 13'h0400,
                          B_LPC  = 13'h0200, B_INC  = 13'h0100, B_LIR  = 13'h0080,
                          B_ADDR = 13'h0040, B_LMAR = 13'h0020, B_ADD  = 13'h0010,
                          B_SUB  = 13'h0008, B_CS   = 13'h0004, B_RNW  = 13'h0002,
                          B_HLT  = 13'h0001;
  localparam logic [12:0] FETCH_S = B_PCB | B_LMAR | B_LPC | B_INC;
  localparam logic [12:0] READ_S  = B_CS | B_RNW | B_LIR;

  function automatic logic [12:0] strb();
    return {bus.ACC_bus, bus.load_ACC, bus.PC_bus, bus.load_PC, bus.INC_PC, bus.load_IR,
            bus.Addr_bus, bus.load_MAR, bus.ALU_add, bus.ALU_sub, bus.CS, bus.R_NW, bus.halted};
  endfunction

  // Leaves the DUT in FETCH at a falling edge, ready for the first check.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    bus.op = 3'b000; bus.z_flag = 1'b0; bus.mem_ready = 1'b0;
    #1;
    got = strb(); vecs++;
    if (got !== 13'h0) begin $display("FAIL rst_hold got=%013b exp=%013b", got, 13'h0); errs++; end
    @(negedge clock); reset = 1'b0; #1;
    got = strb(); vecs++;
    if (got !== FETCH_S) begin $display("FAIL rst_fetch got=%013b exp=%013b", got, FETCH_S); errs++; end
    @(negedge clock); #1;
    got = strb(); vecs++;
    if (got !== (B_CS | B_RNW)) begin $display("FAIL rst_readi got=%013b exp=%013b", got, B_CS | B_RNW); errs++; end
    #2 reset = 1'b1; #1;
    got = strb(); vecs++;
    if (got !== 13'h0) begin $display("FAIL rst_async got=%013b exp=%013b", got, 13'h0); errs++; end
    @(negedge clock); reset = 1'b0; #1;
    got = strb(); vecs++;
    if (got !== FETCH_S) begin $display("FAIL rst_release got=%013b exp=%013b", got, FETCH_S); errs++; end
  endtask

  task automatic test_alu();
    logic [2:0]  ops[3] = '{3'b000, 3'b010, 3'b011};
    logic [12:0] ex_x[3] = '{B_CS | B_RNW | B_LACC,
                             B_CS | B_RNW | B_LACC | B_ADD,
                             B_CS | B_RNW | B_LACC | B_SUB};
    logic [12:0] exp[5];
    logic [12:0] got;
    for (int k = 0; k < 3; k++) begin
      exp = '{FETCH_S, READ_S, B_ADDR | B_LMAR, ex_x[k], FETCH_S};
      do_reset();
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clock);
        bus.op = ops[k]; bus.z_flag = 1'b0; bus.mem_ready = 1'b1; #1;
        got = strb(); vecs++;
        if (got !== exp[i]) begin
          $display("FAIL alu op=%b cyc%0d got=%013b exp=%013b", ops[k], i, got, exp[i]); errs++;
        end
      end
    end
  endtask

  task automatic test_store_wait();
    logic        mr[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [12:0] exp[8] = '{FETCH_S, READ_S, B_ADDR | B_LMAR, B_CS | B_ACCB,
                            B_CS | B_ACCB, B_CS | B_ACCB, B_CS | B_ACCB, FETCH_S};
    logic [12:0] got;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      bus.op = 3'b001; bus.z_flag = 1'b1; bus.mem_ready = mr[i]; #1;
      got = strb(); vecs++;
      if (got !== exp[i]) begin
        $display("FAIL store cyc%0d got=%013b exp=%013b", i, got, exp[i]); errs++;
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  ops[5] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b110};
    logic        zs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [12:0] dec[5] = '{B_ADDR | B_LPC, B_ADDR, B_ADDR, B_ADDR | B_LPC, B_ADDR};
    logic [12:0] exp[4];
    logic [12:0] got;
    for (int k = 0; k < 5; k++) begin
      exp = '{FETCH_S, READ_S, dec[k], FETCH_S};
      do_reset();
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clock);
        bus.op = ops[k]; bus.z_flag = zs[k]; bus.mem_ready = 1'b1; #1;
        got = strb(); vecs++;
        if (got !== exp[i]) begin
          $display("FAIL branch op=%b z=%b cyc%0d got=%013b exp=%013b", ops[k], zs[k], i, got, exp[i]);
          errs++;
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [12:0] exp[3] = '{FETCH_S, READ_S, B_ADDR};
    logic [12:0] got;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      bus.op = 3'b111; bus.z_flag = 1'b0; bus.mem_ready = 1'b1; #1;
      got = strb(); vecs++;
      if (got !== exp[i]) begin $display("FAIL halt_seq cyc%0d got=%013b exp=%013b", i, got, exp[i]); errs++; end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.op = 3'($urandom_range(7)); bus.z_flag = 1'($urandom_range(1));
      bus.mem_ready = 1'($urandom_range(1)); #1;
      got = strb(); vecs++;
      if (got !== B_HLT) begin $display("FAIL halt_hold cyc%0d got=%013b exp=%013b", i, got, B_HLT); errs++; end
    end
    do_reset();
    #1;
    got = strb(); vecs++;
    if (got !== FETCH_S) begin $display("FAIL halt_exit got=%013b exp=%013b", got, FETCH_S); errs++; end
  endtask

  task automatic test_random();
    logic [12:0] got;
    int          drivers;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      reset = (strb() == B_HLT) ? 1'b1 : 1'b0;
      bus.op = 3'($urandom_range(7)); bus.z_flag = 1'($urandom_range(1));
      bus.mem_ready = 1'($urandom_range(1)); #1;
      got = strb();
      drivers = int'(bus.ACC_bus) + int'(bus.PC_bus) + int'(bus.Addr_bus);
      vecs++;
      if (drivers > 1 || (bus.ALU_add && bus.ALU_sub) ||
          (bus.load_IR && !(bus.CS && bus.R_NW)) ||
          (bus.halted && got != B_HLT) || $isunknown(got)) begin
        $display("FAIL invariant cyc%0d got=%013b exp=legal strobe set", i, got); errs++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_wait();
    test_branch();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Control-unit FSM for the basic 8-bit processor. It sits directly downstream of the instruction register.
- Consumes the IR opcode field (op) and the ALU zero flag.
- Produces every bus-drive and register-load strobe, including load_IR and Addr_bus back to the IR.
- Sequences fetch / decode / execute with a wait-state handshake (mem_ready) to memory.

Parameters:
- OP_W, 3, opcode width; must match the IR's OP_W.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  OP_W  opcode from IR
- z_flag  input  1  accumulator-zero flag from ALU
- mem_ready  input  1  memory has completed the current CS access this cycle
- ACC_bus  output  1  accumulator drives sysbus
- load_ACC  output  1  accumulator captures ALU result
- PC_bus  output  1  PC drives sysbus
- load_PC  output  1  PC captures sysbus
- INC_PC  output  1  PC increments (with load_PC)
- load_IR  output  1  IR captures sysbus
- Addr_bus  output  1  IR drives operand address onto sysbus
- load_MAR  output  1  MAR captures sysbus
- ALU_add  output  1  ALU adds sysbus to ACC
- ALU_sub  output  1  ALU subtracts sysbus from ACC
- CS  output  1  memory chip select
- R_NW  output  1  1 = read, 0 = write (meaningful only with CS)
- halted  output  1  FSM is in HALT

Behaviour:
- Opcodes:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 BEQ, 110 NOP, 111 HALT.
  - No other values exist at OP_W=3. If OP_W > 3, any opcode outside this set executes as NOP.
- State register: FETCH, READ_I, DECODE, EXEC, HALT.
  - Outputs are a combinational decode of state, op, z_flag and mem_ready.
  - Every strobe not listed for a state is 0.
- Reset:
  - Async, active-high: state <= FETCH.
  - While reset=1, all outputs are forced to 0. halted=0.
  - Reset mid-access abandons the access. After release, the first cycle is FETCH.
- FETCH:
  - PC_bus=1, load_MAR=1, load_PC=1, INC_PC=1.
  - Next state: READ_I (always; one cycle).
- READ_I:
  - CS=1, R_NW=1.
  - If mem_ready=1: load_IR=1 in the same cycle, next state DECODE. Else stay in READ_I (wait state, strobes held).
- DECODE:
  - Addr_bus=1 in all cases.
  - LOAD/STORE/ADD/SUB: load_MAR=1, next EXEC.
  - BNE: load_PC=1 iff z_flag=0, next FETCH.
  - BEQ: load_PC=1 iff z_flag=1, next FETCH.
  - NOP: next FETCH.
  - HALT: next HALT.
- EXEC, LOAD/ADD/SUB:
  - CS=1, R_NW=1.
  - When mem_ready=1: load_ACC=1. ALU_add=1 for ADD, ALU_sub=1 for SUB, neither for LOAD (ALU pass-through). Next FETCH.
  - Else hold.
- EXEC, STORE:
  - CS=1, R_NW=0, ACC_bus=1.
  - When mem_ready=1: next FETCH. Else hold.
- HALT:
  - halted=1, all other outputs 0. Exits only on reset.
- Invariants:
  - At most one of ACC_bus, PC_bus, Addr_bus is 1 in any cycle (single sysbus driver).
  - ALU_add and ALU_sub are never both 1.
  - load_IR is asserted only in READ_I.
- op is sampled only in DECODE and EXEC. The IR holds op stable across EXEC, so no internal latch is needed.
- Instruction latency with mem_ready tied high:
  - LOAD/STORE/ADD/SUB: 4 cycles.
  - BNE/BEQ/NOP: 3 cycles.
  - Each wait cycle adds 1.

Decomposition:
- cpu_pkg holds:
  - the opcode enum typedef (opcode_t, with the values above);
  - the state enum typedef (seq_state_t);
  - OP_W as a localparam default.
- The IR and ALU share the same package.
- No sub-module. The block is a single FSM: one always_ff for state, one always_comb for next-state/outputs.

Test Plan:
1. reset=1 mid-READ_I with CS=1 -> all outputs 0 immediately (asynchronously). Release -> cycle 1 shows PC_bus=1, load_MAR=1, INC_PC=1.
2. mem_ready=1 always, op=010 (ADD) -> strobe sequence FETCH, READ_I (load_IR), DECODE (Addr_bus, load_MAR), EXEC (CS, R_NW, load_ACC, ALU_add). Next FETCH at cycle 5.
3. op=001 (STORE), mem_ready low for 3 cycles in EXEC -> CS=1, R_NW=0, ACC_bus=1 held 4 cycles. Then FETCH; load_ACC never 1.
4. op=100 (BNE): z_flag=0 -> DECODE asserts Addr_bus+load_PC. z_flag=1 -> Addr_bus only, load_PC=0. Both return to FETCH next cycle. Repeat for op=101 with z_flag inverted.
5. op=111 (HALT) -> halted=1 from cycle 4 onward, all strobes 0 for 20 cycles regardless of mem_ready/op changes. reset pulse -> FETCH, halted=0.
6. Random op/z_flag/mem_ready for 10k cycles -> assertions hold: single bus driver, not (ALU_add and ALU_sub), load_IR only with CS and R_NW, no state other than the five.
